cdiv: RTL and testbench

Iterative complex divider computing q = a / b for signed fixed-point complex operands, the inverse operation to the DSP complex multiplier in the same library. Evaluates q = a·conj(b) / |b|² as two parallel bit-serial unsigned divisions sharing one denominator. It sits on valid/ready streams in DSP datapaths, such as equaliser tap solving and normalisation, where throughput of one result per ~QWIDTH cycles is sufficient.

---
 rtl/cdiv_pkg.sv | 35 +++
 rtl/cdiv_lane.sv | 60 ++++++
 rtl/cdiv.sv | 193 +++++++++++++++++++
 tb/tb_cdiv.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cdiv_pkg.sv
// Shared types and width helpers for the iterative complex divider.
// Widths are parameters of cdiv; the helpers derive the internal datapath widths from them.
package cdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROD,
        CHK,
        DIV,
        DONE
    } state_t;

    localparam int AWIDTH_DEF = 16;
    localparam int BWIDTH_DEF = 16;
    localparam int QWIDTH_DEF = 16;
    localparam int FRAC_DEF   = 15;
    localparam int NWIDTH     = AWIDTH_DEF + BWIDTH_DEF + 1;
    localparam int DWIDTH     = 2 * BWIDTH_DEF;

    function automatic int nwidth(input int aw, input int bw);
        return aw + bw + 1;
    endfunction

    function automatic int dwidth(input int bw);
        return 2 * bw;
    endfunction

    // Symmetric saturation: +/-(2^(qw-1)-1), so the most negative code never appears.
    function automatic logic [31:0] sat_val(input int qw, input logic neg);
        logic [31:0] mag;
        mag = (32'd1 << (qw - 1)) - 32'd1;
        return neg ? (32'd0 - mag) : mag;
    endfunction

endpackage

// File: rtl/cdiv_lane.sv
// One unsigned restoring-division lane: magnitude |n|*2^FRAC divided by den.
// It produces one quotient bit per step; q_o shows the quotient after the current step.
module cdiv_lane
    import cdiv_pkg::*;
#(
    parameter int MW   = 32,
    parameter int DW   = 32,
    parameter int QW   = 16,
    parameter int FRAC = 15
) (
    input  logic          clk,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [MW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic [QW-2:0] q_o
);

    localparam int SW = MW + FRAC;
    localparam int MQ = QW - 1;

    logic [DW-1:0] rem_q, rem_d;
    logic [MQ-1:0] low_q, low_d;
    logic [MQ-1:0] quo_q, quo_d;
    logic [SW-1:0] full;
    logic [DW:0]   trial;

    // The upper part of the dividend is already below den (the overflow check
    // guarantees it), so it seeds the remainder and only MQ bits remain to shift in.
    always_comb begin
        full  = SW'(num_i) << FRAC;
        trial = {rem_q, low_q[MQ-1]};
        rem_d = rem_q;
        low_d = low_q;
        quo_d = quo_q;
        if (load_i) begin
            rem_d = DW'(full >> MQ);
            low_d = full[MQ-1:0];
            quo_d = '0;
        end else if (step_i) begin
            low_d = low_q << 1;
            if (trial >= {1'b0, den_i}) begin
                rem_d = DW'(trial - {1'b0, den_i});
                quo_d = {quo_q[MQ-2:0], 1'b1};
            end else begin
                rem_d = trial[DW-1:0];
                quo_d = {quo_q[MQ-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        low_q <= low_d;
        quo_q <= quo_d;
    end

    assign q_o = quo_d;

endmodule

// File: rtl/cdiv.sv
// Iterative complex divider q = a*conj(b)/|b|^2 with two bit-serial lanes sharing d.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module cdiv
    import cdiv_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16,
    parameter int QWIDTH = 16,
    parameter int FRAC   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [AWIDTH-1:0] ar,
    input  logic signed [AWIDTH-1:0] ai,
    input  logic signed [BWIDTH-1:0] br,
    input  logic signed [BWIDTH-1:0] bi,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [QWIDTH-1:0] qr,
    output logic signed [QWIDTH-1:0] qi,
    output logic                     dbz,
    output logic                     ovf
);

    localparam int NW = nwidth(AWIDTH, BWIDTH);
    localparam int DW = dwidth(BWIDTH);
    localparam int MW = NW - 1;
    localparam int MQ = QWIDTH - 1;
    localparam int SW = MW + FRAC;
    localparam int CW = $clog2(QWIDTH);

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic signed [QWIDTH-1:0] qr_q, qr_d, qi_q, qi_d;
    logic dbz_q, dbz_d, ovf_q, ovf_d;

    logic signed [AWIDTH-1:0] ar_q, ai_q;
    logic signed [BWIDTH-1:0] br_q, bi_q;
    logic signed [NW-1:0] nr_q, ni_q, nr_d, ni_d;
    logic [DW-1:0] d_q, d_d;

    logic signed [AWIDTH+BWIDTH-1:0] m_rr, m_ii, m_ir, m_ri;
    logic signed [2*BWIDTH-1:0] m_bb, m_cc;
    logic signed [NW-1:0] abs_r, abs_i;
    logic [MW-1:0] mag_r, mag_i;
    logic [SW-1:0] sh_r, sh_i;
    logic ovf_r, ovf_i, triv_r, triv_i;
    logic [31:0] sat32_r, sat32_i;
    logic [QWIDTH-1:0] ext_r, ext_i;
    logic signed [QWIDTH-1:0] res_r, res_i;
    logic [MQ-1:0] qm_r, qm_i;
    logic lane_load, lane_step;

    always_comb begin
        m_rr = ar_q * br_q;
        m_ii = ai_q * bi_q;
        m_ir = ai_q * br_q;
        m_ri = ar_q * bi_q;
        m_bb = br_q * br_q;
        m_cc = bi_q * bi_q;
        nr_d = NW'(m_rr) + NW'(m_ii);
        ni_d = NW'(m_ir) - NW'(m_ri);
        d_d  = $unsigned(m_bb) + $unsigned(m_cc);
    end

    // A component overflows when |n|*2^FRAC >= d*2^(QWIDTH-1); a zero numerator
    // needs no iterations either, so both count as already resolved in CHK.
    always_comb begin
        abs_r   = nr_q[NW-1] ? -nr_q : nr_q;
        abs_i   = ni_q[NW-1] ? -ni_q : ni_q;
        mag_r   = MW'(abs_r);
        mag_i   = MW'(abs_i);
        sh_r    = (SW'(mag_r) << FRAC) >> MQ;
        sh_i    = (SW'(mag_i) << FRAC) >> MQ;
        ovf_r   = sh_r >= SW'(d_q);
        ovf_i   = sh_i >= SW'(d_q);
        triv_r  = ovf_r || (nr_q == '0);
        triv_i  = ovf_i || (ni_q == '0);
        sat32_r = sat_val(QWIDTH, nr_q[NW-1]);
        sat32_i = sat_val(QWIDTH, ni_q[NW-1]);
        ext_r   = {1'b0, qm_r};
        ext_i   = {1'b0, qm_i};
        res_r   = ovf_r ? QWIDTH'(sat32_r) : (nr_q[NW-1] ? -ext_r : ext_r);
        res_i   = ovf_i ? QWIDTH'(sat32_i) : (ni_q[NW-1] ? -ext_i : ext_i);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qr_d      = qr_q;
        qi_d      = qi_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        lane_load = 1'b0;
        lane_step = 1'b0;
        case (state_q)
            IDLE: if (s_valid) state_d = PROD;
            PROD: state_d = CHK;
            CHK: begin
                lane_load = 1'b1;
                cnt_d     = '0;
                if (d_q == '0) begin
                    state_d = DONE;
                    qr_d    = '0;
                    qi_d    = '0;
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else if (triv_r && triv_i) begin
                    state_d = DONE;
                    qr_d    = res_r;
                    qi_d    = res_i;
                    dbz_d   = 1'b0;
                    ovf_d   = ovf_r || ovf_i;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                lane_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(MQ - 1)) begin
                    state_d = DONE;
                    qr_d    = res_r;
                    qi_d    = res_i;
                    dbz_d   = 1'b0;
                    ovf_d   = ovf_r || ovf_i;
                end
            end
            DONE: if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qr_q    <= '0;
            qi_q    <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qr_q    <= qr_d;
            qi_q    <= qi_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_valid && s_ready) begin
            ar_q <= ar;
            ai_q <= ai;
            br_q <= br;
            bi_q <= bi;
        end
        if (state_q == PROD) begin
            nr_q <= nr_d;
            ni_q <= ni_d;
            d_q  <= d_d;
        end
    end

    cdiv_lane #(.MW(MW), .DW(DW), .QW(QWIDTH), .FRAC(FRAC)) u_lane_r (
        .clk    (clk),
        .load_i (lane_load),
        .step_i (lane_step),
        .num_i  (mag_r),
        .den_i  (d_q),
        .q_o    (qm_r)
    );

    cdiv_lane #(.MW(MW), .DW(DW), .QW(QWIDTH), .FRAC(FRAC)) u_lane_i (
        .clk    (clk),
        .load_i (lane_load),
        .step_i (lane_step),
        .num_i  (mag_i),
        .den_i  (d_q),
        .q_o    (qm_i)
    );

    assign s_ready = (state_q == IDLE) && !rst;
    assign m_valid = (state_q == DONE);
    assign qr      = qr_q;
    assign qi      = qi_q;
    assign dbz     = dbz_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_cdiv.sv
// Bench for cdiv: directed cases plus random operands against an arithmetic reference model.
module tb_cdiv;
  localparam int QW   = 16;
  localparam int FRAC = 15;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_ready, m_valid, m_ready, dbz, ovf;
  logic signed [15:0] ar, ai, br, bi, qr, qi;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  cdiv dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi),
    .m_valid(m_valid), .m_ready(m_ready),
    .qr(qr), .qi(qi), .dbz(dbz), .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // reference: |q| = floor(|n|*2^FRAC/d), saturate when that reaches 2^(QW-1)
  function automatic logic [15:0] comp(input longint n, input longint d, output bit sat);
    longint m, q;
    m   = (n < 0) ? -n : n;
    sat = (m <<< FRAC) >= (d <<< (QW - 1));
    q   = sat ? ((longint'(1) <<< (QW - 1)) - 1) : ((m <<< FRAC) / d);
    if (n < 0) q = -q;
    return 16'(q);
  endfunction

  task automatic model(input logic signed [15:0] a_r, a_i, b_r, b_i,
                       output logic [33:0] exp_v, output int lat);
    longint nr, ni, d;
    logic [15:0] q_r, q_i;
    bit s_r, s_i;
    nr = longint'(a_r) * longint'(b_r) + longint'(a_i) * longint'(b_i);
    ni = longint'(a_i) * longint'(b_r) - longint'(a_r) * longint'(b_i);
    d  = longint'(b_r) * longint'(b_r) + longint'(b_i) * longint'(b_i);
    if (d == 0) begin
      exp_v = {32'd0, 1'b1, 1'b0};
      lat   = 3;
    end else begin
      q_r   = comp(nr, d, s_r);
      q_i   = comp(ni, d, s_i);
      exp_v = {q_r, q_i, 1'b0, s_r | s_i};
      lat   = ((s_r || nr == 0) && (s_i || ni == 0)) ? 3 : QW + 2;
    end
  endtask

  task automatic scramble();
    ar = 16'($urandom);
    ai = 16'($urandom);
    br = 16'($urandom);
    bi = 16'($urandom);
  endtask

  // driver: one full transaction with `hold` cycles of backpressure
  task automatic do_op(input logic signed [15:0] a_r, a_i, b_r, b_i, input int hold);
    logic [33:0] exp_v, first;
    int lat, k;
    model(a_r, a_i, b_r, b_i, exp_v, lat);
    exp_q.push_back(exp_v);
    ar = a_r; ai = a_i; br = b_r; bi = b_i;
    s_valid = 1'b1;
    check("s_ready_idle", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    scramble();
    k = 0;
    while (!m_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", 64'(k + 1), 64'(lat));
    first = {qr, qi, dbz, ovf};
    repeat (hold) begin
      s_valid = 1'($urandom_range(0, 1));
      scramble();
      @(posedge clk); #1;
      check("hold_valid", 64'(m_valid), 64'(1));
      check("hold_stable", 64'({qr, qi, dbz, ovf}), 64'(first));
      check("hold_ready", 64'(s_ready), 64'(0));
    end
    s_valid = 1'b0;
    check("result", 64'({qr, qi, dbz, ovf}), 64'(exp_q.pop_front()));
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("post_ready", 64'(s_ready), 64'(1));
    check("post_valid", 64'(m_valid), 64'(0));
  endtask

  initial begin
    int seen;
    logic signed [15:0] ra, rb, rc, rd;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_outputs", 64'({qr, qi, dbz, ovf}), 64'(0));
    rst = 1'b0;
    #1;
    check("rel_s_ready", 64'(s_ready), 64'(1));

    do_op(16'sd8192, 16'sd8192, 16'sd16384, 16'sd0, 0);
    do_op(-16'sd8192, 16'sd0, 16'sd0, 16'sd16384, 1);
    do_op(16'sd1, 16'sd0, 16'sd3, 16'sd0, 0);
    do_op(-16'sd1, 16'sd0, 16'sd3, 16'sd0, 0);
    do_op(16'sd0, 16'sd16384, 16'sd0, 16'sd16384, 0);
    do_op(16'sd32767, 16'sd1, 16'sd1, 16'sd0, 0);
    do_op(-16'sd32768, 16'sd5, 16'sd1, 16'sd0, 0);
    do_op(16'sd100, -16'sd5, 16'sd0, 16'sd0, 0);
    do_op(16'sd1000, -16'sd3000, 16'sd7000, -16'sd2000, 10);
    do_op(16'sd1234, 16'sd4321, -16'sd9000, 16'sd5000, 0);

    // reset in the middle of a normal operation
    ar = 16'sd8192; ai = 16'sd8192; br = 16'sd16384; bi = 16'sd0;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_m_valid", 64'(m_valid), 64'(0));
    check("midrst_outputs", 64'({qr, qi, dbz, ovf}), 64'(0));
    check("midrst_s_ready", 64'(s_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("midrst_release", 64'(s_ready), 64'(1));
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (m_valid) seen++;
    end
    check("midrst_no_emit", 64'(seen), 64'(0));
    do_op(16'sd8192, 16'sd8192, 16'sd16384, 16'sd0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: begin rc = 16'($urandom); rd = 16'($urandom); end
        1: begin rc = 16'($urandom_range(0, 6)) - 16'sd3; rd = 16'($urandom_range(0, 2)) - 16'sd1; end
        2: begin rc = 16'sd0; rd = 16'sd0; end
        default: begin rc = 16'($urandom_range(0, 400)) - 16'sd200; rd = 16'($urandom); end
      endcase
      do_op(ra, rb, rc, rd, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
